// File: rtl/board_change_detector_pkg.sv
// board_pkg: board geometry, FSM state type and a popcount helper shared
// by the board change detector, its interface and its sub-module.
package board_pkg;

    localparam int BOARD_W = 32;
    localparam int IDX_W   = 5;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LIFTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    // Number of set bits in a board snapshot.
    function automatic logic [IDX_W:0] popcount(input logic [BOARD_W-1:0] vec);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < BOARD_W; i++) begin
            n = n + (IDX_W+1)'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/board_change_detector_if.sv
// Scanner / memory-manager side signals of the board change detector.
// master = scanner + status consumer, slave = the detector itself.
// Optional port piece_count exists only when PIECE_COUNT_EN is defined.
interface board_change_detector_if;
    import board_pkg::*;

    logic               scan_valid;
    logic [BOARD_W-1:0] scan_data;
    logic               clear_error;
    logic               board_valid;
    logic [BOARD_W-1:0] stable_board;
    logic               changed;
    logic               move_done;
    logic [IDX_W-1:0]   move_from;
    logic [IDX_W-1:0]   move_to;
    logic               error;
`ifdef PIECE_COUNT_EN
    logic [IDX_W:0]     piece_count;
`endif

    modport master (
        output scan_valid, scan_data, clear_error,
        input  board_valid, stable_board, changed, move_done,
               move_from, move_to, error
`ifdef PIECE_COUNT_EN
        , input piece_count
`endif
    );

    modport slave (
        input  scan_valid, scan_data, clear_error,
        output board_valid, stable_board, changed, move_done,
               move_from, move_to, error
`ifdef PIECE_COUNT_EN
        , output piece_count
`endif
    );

endinterface

// File: rtl/board_change_detector_lsb_index_encoder.sv
// lsb_index_encoder: combinational lowest-set-bit to index converter.
// An all-zero vector encodes as index 0.
module lsb_index_encoder
    import board_pkg::*;
(
    input  logic [BOARD_W-1:0] vec_i,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: idx_o gets a default before the loop so no path leaves it unassigned (no latch).
        idx_o = '0;
        for (int i = BOARD_W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/board_change_detector.sv
// board_change_detector: debounces raw Hall-sensor snapshots into a stable
// board and tracks a lift-then-place human move against a baseline board.
// Define PIECE_COUNT_EN to add the registered piece_count output.
module board_change_detector
    import board_pkg::*;
#(
    parameter int STABLE_SCANS = 4   // legal range 2..15
) (
    input  logic                   clk,
    input  logic                   rst,
    board_change_detector_if.slave bus
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_SCANS);

    logic [BOARD_W-1:0] cand_q, cand_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BOARD_W-1:0] stable_q, stable_d;
    logic [BOARD_W-1:0] baseline_q, baseline_d;
    state_t             state_q, state_d;
    logic               board_valid_q, board_valid_d;
    logic               changed_q, changed_d;
    logic               move_done_q, move_done_d;
    logic [IDX_W-1:0]   move_from_q, move_from_d;
    logic [IDX_W-1:0]   move_to_q, move_to_d;

    logic               accept;
    logic [BOARD_W-1:0] lifted, placed;
    logic [IDX_W-1:0]   lifted_idx, placed_idx;
    logic [IDX_W:0]     placed_cnt;

    // At acceptance the candidate equals the incoming snapshot, so it is the new board.
    assign accept     = bus.scan_valid && (bus.scan_data == cand_q) && (cnt_q == CNT_MAX - 4'd1);
    assign lifted     = baseline_q & ~cand_q;
    assign placed     = cand_q & ~baseline_q;
    assign placed_cnt = popcount(placed);

    lsb_index_encoder u_lifted_enc (.vec_i(lifted), .idx_o(lifted_idx));
    lsb_index_encoder u_placed_enc (.vec_i(placed), .idx_o(placed_idx));

    // Next-state: debounce counter, board acceptance and move-tracking FSM.
    always_comb begin
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        stable_d      = stable_q;
        baseline_d    = baseline_q;
        state_d       = state_q;
        board_valid_d = board_valid_q;
        changed_d     = 1'b0;
        move_done_d   = 1'b0;
        move_from_d   = move_from_q;
        move_to_d     = move_to_q;

        if (bus.scan_valid) begin
            if (bus.scan_data == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cand_d = bus.scan_data;
                cnt_d  = 4'd1;
            end
        end

        if (bus.clear_error) begin
            // Rebase wins over a same-cycle acceptance, which is dropped.
            baseline_d = stable_q;
            if (state_q != ST_INIT) begin
                state_d = ST_IDLE;
            end
        end else if (accept) begin
            if (state_q == ST_INIT) begin
                stable_d      = cand_q;
                baseline_d    = cand_q;
                board_valid_d = 1'b1;
                state_d       = ST_IDLE;
            end else if (cand_q != stable_q) begin
                stable_d  = cand_q;
                changed_d = 1'b1;
                case (state_q)
                    ST_IDLE: begin
                        if (placed != '0) begin
                            state_d = ST_ERROR;
                        end else if (lifted != '0) begin
                            move_from_d = lifted_idx;
                            state_d     = ST_LIFTED;
                        end
                    end
                    ST_LIFTED: begin
                        if (cand_q == baseline_q) begin
                            state_d = ST_IDLE;
                        end else if (placed_cnt == (IDX_W+1)'(1)) begin
                            move_to_d   = placed_idx;
                            move_done_d = 1'b1;
                            baseline_d  = cand_q;
                            state_d     = ST_IDLE;
                        end else if (placed_cnt != '0) begin
                            state_d = ST_ERROR;
                        end
                    end
                    ST_ERROR: begin
                        if (cand_q == baseline_q) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_INIT;
                endcase
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cand_q        <= '0;
            cnt_q         <= '0;
            stable_q      <= '0;
            baseline_q    <= '0;
            state_q       <= ST_INIT;
            board_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            move_done_q   <= 1'b0;
            move_from_q   <= '0;
            move_to_q     <= '0;
        end else begin
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            baseline_q    <= baseline_d;
            state_q       <= state_d;
            board_valid_q <= board_valid_d;
            changed_q     <= changed_d;
            move_done_q   <= move_done_d;
            move_from_q   <= move_from_d;
            move_to_q     <= move_to_d;
        end
    end

`ifdef PIECE_COUNT_EN
    logic [IDX_W:0] piece_count_q;

    // Piece count tracks the stable board on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            piece_count_q <= '0;
        end else begin
            piece_count_q <= popcount(stable_d);
        end
    end

    assign bus.piece_count = piece_count_q;
`endif

    assign bus.board_valid  = board_valid_q;
    assign bus.stable_board = stable_q;
    assign bus.changed      = changed_q;
    assign bus.move_done    = move_done_q;
    assign bus.move_from    = move_from_q;
    assign bus.move_to      = move_to_q;
    assign bus.error        = (state_q == ST_ERROR);

endmodule
